// File: rtl/i_ref_ramp_if.sv
// Signal bundle between the sweep controller/sampler side and the i_ref ramp generator.
// The ramp generator is the slave; the sweep side that drives enable/instability is the master.
interface i_ref_ramp_if #(
    parameter int BUS_WIDTH = 10
);
    logic                 enable;
    logic                 went_unstable;
    logic [BUS_WIDTH-1:0] i_ref_max;
    logic [BUS_WIDTH-1:0] i_ref;
    logic                 ready;
    logic                 done;
    logic                 at_limit;

    modport master (
        output enable, went_unstable, i_ref_max,
        input  i_ref, ready, done, at_limit
    );

    modport slave (
        input  enable, went_unstable, i_ref_max,
        output i_ref, ready, done, at_limit
    );
endinterface

// File: rtl/i_ref_ramp.sv
// Stepped reference-current ramp for the stability sweep: settle, strobe ready, step,
// and on instability back off to the last stable code from i_ref_sampling and hold it.
//
// state   | meaning
// IDLE    | i_ref parked at I_START, waiting for enable
// SETTLE  | current step settling for SETTLE_CYCLES cycles
// SAMPLE  | one-cycle ready strobe, i_ref steps on the closing edge
// BACKOFF | one cycle, i_ref_max from the sampler is applied here
// HOLD    | sweep finished, i_ref frozen until enable drops
module i_ref_ramp #(
    parameter int BUS_WIDTH     = 10,
    parameter int I_START       = 0,
    parameter int STEP          = 1,
    parameter int SETTLE_CYCLES = 16
) (
    input logic          clk,
    input logic          rst,
    i_ref_ramp_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        SAMPLE  = 3'd2,
        BACKOFF = 3'd3,
        HOLD    = 3'd4
    } state_t;

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [BUS_WIDTH-1:0] CODE_INIT = BUS_WIDTH'(I_START);
    localparam logic [BUS_WIDTH:0]   CODE_MAX  = {1'b0, {BUS_WIDTH{1'b1}}};
    localparam logic [BUS_WIDTH:0]   STEP_EXT  = (BUS_WIDTH+1)'(STEP);

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [2:0]           shift, shift_nxt;
    logic [BUS_WIDTH-1:0] i_ref_q, i_ref_nxt;
    logic                 ready_q, done_q, at_limit_q, at_limit_nxt;
    logic [BUS_WIDTH:0]   code_sum;

    assign code_sum = {1'b0, i_ref_q} + STEP_EXT;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shift      <= '0;
            i_ref_q    <= CODE_INIT;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            at_limit_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            shift      <= shift_nxt;
            i_ref_q    <= i_ref_nxt;
            ready_q    <= (state_nxt == SAMPLE);
            done_q     <= (state_nxt == HOLD);
            at_limit_q <= at_limit_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        shift_nxt    = shift;
        i_ref_nxt    = i_ref_q;
        at_limit_nxt = at_limit_q;
        if (!bus.enable) begin
            state_nxt    = IDLE;
            cnt_nxt      = '0;
            shift_nxt    = '0;
            i_ref_nxt    = CODE_INIT;
            at_limit_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = SETTLE;
                    cnt_nxt   = '0;
                end
                SETTLE: begin
                    if (bus.went_unstable) begin
                        state_nxt = BACKOFF;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = SAMPLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    if (bus.went_unstable) begin
                        state_nxt = BACKOFF;
                    end else begin
                        if (shift != 3'd4) shift_nxt = shift + 3'd1;
                        if (code_sum > CODE_MAX) begin
                            state_nxt    = HOLD;
                            at_limit_nxt = 1'b1;
                        end else begin
                            state_nxt = SETTLE;
                            cnt_nxt   = '0;
                            i_ref_nxt = code_sum[BUS_WIDTH-1:0];
                        end
                    end
                end
                BACKOFF: begin
                    // Before four good samples the sampler history still holds its all-ones reset value.
                    i_ref_nxt = (shift == 3'd4) ? bus.i_ref_max : CODE_INIT;
                    state_nxt = HOLD;
                end
                HOLD: state_nxt = HOLD;
                default: begin
                    state_nxt = IDLE;
                    i_ref_nxt = CODE_INIT;
                end
            endcase
        end
    end

    assign bus.i_ref    = i_ref_q;
    assign bus.ready    = ready_q;
    assign bus.done     = done_q;
    assign bus.at_limit = at_limit_q;
endmodule

// File: doc/i_ref_ramp.md
# i_ref_ramp

Generates the stepped reference current code `i_ref` for the stability sweep and issues the `ready` sample strobe to `i_ref_sampling`. It ramps `i_ref` upward from a start code, lets each step settle, then strobes `ready`. On `went_unstable` it backs off to the last known-stable code (`i_ref_max`, returned by `i_ref_sampling`) and holds it. It sits between the sweep-control logic and the DAC driving the reference current.

## Interface
- `BUS_WIDTH`, 10: width of the `i_ref` code. Must match `i_ref_sampling`.
- `I_START`, 0: code loaded at reset/idle. Must be less than 2**BUS_WIDTH.
- `STEP`, 1: increment per step. Must be at least 1.
- `SETTLE_CYCLES`, 16: settle cycles per step. Must be at least 1.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  level. High runs or holds the sweep; low returns the block to IDLE.
- `went_unstable`  in  1  instability flag from the loop monitor; shared with `i_ref_sampling`.
- `i_ref_max`  in  BUS_WIDTH  last-stable code from `i_ref_sampling`.
- `i_ref`  out  BUS_WIDTH  reference code, registered.
- `ready`  out  1  one-cycle sample strobe, registered.
- `done`  out  1  high in HOLD.
- `at_limit`  out  1  high in HOLD when the sweep ended on code overflow rather than instability.

## Operation
- States: IDLE, SETTLE, SAMPLE, BACKOFF, HOLD.
- Reset values: state=IDLE, `i_ref`=I_START, `ready`=0, `done`=0, `at_limit`=0, settle counter=0, shift count=0.
- `enable` low in any state forces IDLE on the next edge:
  - `i_ref`=I_START.
  - `ready`, `done`, `at_limit` cleared.
  - Counters cleared.
  - This has priority over `went_unstable`.
- IDLE: when `enable`=1, go to SETTLE with the settle counter at 0.
- SETTLE:
  - Counter increments each cycle.
  - After exactly SETTLE_CYCLES cycles, go to SAMPLE.
  - `went_unstable`=1 goes to BACKOFF immediately.
- SAMPLE: lasts one cycle with `ready`=1 and `i_ref` unchanged.
  - If `went_unstable`=1: go to BACKOFF. Shift count is not incremented.
  - Otherwise, increment shift count (saturating at 4). Then:
    - If `i_ref`+STEP > 2**BUS_WIDTH-1: go to HOLD with `at_limit`=1 and `i_ref` unchanged.
    - Else: `i_ref` <= `i_ref`+STEP and go to SETTLE.
- BACKOFF: one cycle, `ready`=0. `i_ref_max` is valid during this cycle because the sampler latched it on the `went_unstable` edge.
  - If shift count = 4: `i_ref` <= `i_ref_max`.
  - Else: `i_ref` <= I_START, because the sampler's history still holds reset all-ones.
  - Then go to HOLD.
- HOLD:
  - `done`=1; `i_ref` is frozen.
  - `went_unstable` is ignored.
  - Exits only via `enable` low or `rst`.
- `went_unstable` is ignored in IDLE and HOLD.
- Arithmetic: compute the increment at BUS_WIDTH+1 bits for the overflow test. `i_ref` never wraps.

## Timing
- `enable` rises in cycle 0 while in IDLE.
  - SETTLE occupies cycles 1..SETTLE_CYCLES.
  - `ready` is high in cycle SETTLE_CYCLES+1.
- Step period is SETTLE_CYCLES+1 cycles.
- `i_ref` changes on the edge ending the `ready` cycle, so the sampler captures the pre-step value.
- Instability latency: `went_unstable` seen in cycle t leads to BACKOFF in t+1, new `i_ref` and `done`=1 in t+2.
- `ready` is never high in two consecutive cycles.
- `ready` is never high in IDLE, BACKOFF or HOLD.
- `rst` mid-operation in any state yields the reset values on the next edge.

## Test plan
All scenarios use BUS_WIDTH=10, I_START=100, STEP=8, SETTLE_CYCLES=4, with `i_ref_sampling` instantiated alongside.
- Reset: assert `rst` for 2 cycles -> `i_ref`=100, `ready`=0, `done`=0, `at_limit`=0.
- Stable ramp: `enable`=1 from cycle 0 -> `ready` pulses in cycles 5, 10, 15, 20 with `i_ref`=100, 108, 116, 124 during the pulses; `ready` low in all other cycles.
- Unstable after full history: `went_unstable` during the 6th `ready` pulse (`i_ref`=140) -> `i_ref_max`=108; `i_ref`=108 and `done`=1 two cycles later; `i_ref` held for 50 further cycles.
- Early instability: `went_unstable` during the 2nd SETTLE -> `i_ref`=100 (I_START), `done`=1, `at_limit`=0.
- Saturation: I_START=1000 -> pulses at 1000, 1008, 1016; then HOLD with `i_ref`=1016, `at_limit`=1, `done`=1.
- Abort:
  - `enable` dropped mid-SETTLE -> `i_ref`=100 next cycle, no further `ready`.
  - `rst` asserted during BACKOFF -> reset values next cycle; `i_ref_max` is not applied.
